// File: rtl/regfile_sweep_master.sv
// regfile_sweep_master
//   Client-side initiator for the register-file model. Runs one command at a
//   time over a contiguous index range:
//     fill  - writes SEED (+i when INC) to indices BASE..BASE+COUNT-1, one per cycle
//     check - reads the same range back and accumulates a wrap-around checksum
//
//   Ports
//     CLK, RST_N                  clock, asynchronous active-low reset
//     START, START_MODE,          command strobe (accepted only in IDLE) and
//     START_BASE, START_COUNT,    command fields, latched on acceptance
//     START_SEED, START_INC
//     BUSY, DONE, ERR             status: busy, completion pulse, reject pulse
//     SUM                         checksum of the last check command
//     READ_REQ_WRITE(_VALID)      read request to target
//     READ_RESP_READ(_VALID)      combinational read response from target
//     WRITE_EN_WRITE, WRITE_INDEX_WRITE, WRITE_DATA_WRITE   write port to target
//     MISMATCH, MISMATCH_INDEX    first check failure (SWEEP_VERIFY_EN only)
//
//   Optional feature macro: SWEEP_VERIFY_EN (readback comparator). When it is
//   undefined, MISMATCH and MISMATCH_INDEX are tied to 0.
module regfile_sweep_master #(
   parameter int width = 32,
   parameter int n     = 5,
   parameter int size  = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             START_MODE,
   input  logic [n-1:0]     START_BASE,
   input  logic [n:0]       START_COUNT,
   input  logic [width-1:0] START_SEED,
   input  logic             START_INC,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [width-1:0] SUM,
   output logic [n-1:0]     READ_REQ_WRITE,
   output logic             READ_REQ_WRITE_VALID,
   input  logic [width-1:0] READ_RESP_READ,
   input  logic             READ_RESP_READ_VALID,
   output logic             WRITE_EN_WRITE,
   output logic [n-1:0]     WRITE_INDEX_WRITE,
   output logic [width-1:0] WRITE_DATA_WRITE,
   output logic             MISMATCH,
   output logic [n-1:0]     MISMATCH_INDEX
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] FIN   = 2'd3;

   logic [1:0]       state;
   logic [n-1:0]     idx;
   logic [width-1:0] pat;
   logic [n:0]       remaining;
   logic             inc;
   logic [width-1:0] sum;
   logic             err_q;

   // Range end computed two bits wider than the index so BASE+COUNT cannot wrap.
   logic [n+1:0]     range_end;
   logic             too_big;
   logic             accept;
   logic             last_beat;

   always_comb begin
      range_end = (n+2)'(START_BASE) + (n+2)'(START_COUNT);
      too_big   = range_end > (n+2)'(size);
      accept    = (state == IDLE) && START && !too_big && (START_COUNT != '0);
      last_beat = (remaining == (n+1)'(1));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         idx       <= '0;
         pat       <= '0;
         remaining <= '0;
         inc       <= 1'b0;
         sum       <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  if (too_big) begin
                     err_q <= 1'b1;
                  end else if (START_COUNT == '0) begin
                     state <= FIN;
                  end else begin
                     idx       <= START_BASE;
                     pat       <= START_SEED;
                     remaining <= START_COUNT;
                     inc       <= START_INC;
                     if (START_MODE) begin
                        state <= CHECK;
                        sum   <= '0;
                     end else begin
                        state <= FILL;
                     end
                  end
               end
            end
            FILL: begin
               idx       <= idx + 1'b1;
               pat       <= pat + width'(inc);
               remaining <= remaining - 1'b1;
               if (last_beat) state <= FIN;
            end
            CHECK: begin
               // A low response valid stalls with index and request held.
               if (READ_RESP_READ_VALID) begin
                  sum       <= sum + READ_RESP_READ;
                  idx       <= idx + 1'b1;
                  pat       <= pat + width'(inc);
                  remaining <= remaining - 1'b1;
                  if (last_beat) state <= FIN;
               end
            end
            default: state <= IDLE;   // FIN: DONE shown for exactly this cycle
         endcase
      end
   end

`ifdef SWEEP_VERIFY_EN
   logic         mm;
   logic [n-1:0] mm_idx;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mm     <= 1'b0;
         mm_idx <= '0;
      end else if (accept && START_MODE) begin
         mm     <= 1'b0;
         mm_idx <= '0;
      end else if ((state == CHECK) && READ_RESP_READ_VALID && !mm &&
                   (READ_RESP_READ != pat)) begin
         // Only the first failing word is recorded.
         mm     <= 1'b1;
         mm_idx <= idx;
      end
   end

   assign MISMATCH       = mm;
   assign MISMATCH_INDEX = mm_idx;
`else
   assign MISMATCH       = 1'b0;
   assign MISMATCH_INDEX = '0;
`endif

   assign BUSY                 = (state == FILL) || (state == CHECK);
   assign DONE                 = (state == FIN);
   assign ERR                  = err_q;
   assign SUM                  = sum;
   assign READ_REQ_WRITE       = idx;
   assign READ_REQ_WRITE_VALID = (state == CHECK);
   assign WRITE_EN_WRITE       = (state == FILL);
   assign WRITE_INDEX_WRITE    = idx;
   assign WRITE_DATA_WRITE     = pat;

endmodule

// File: tb/tb_regfile_sweep_master.sv
// tb_regfile_sweep_master
//   Table-driven bench for regfile_sweep_master with a behavioural register
//   file as the target. Expected write/read beats are queued when a command is
//   issued and popped as the port activity appears.
module tb_regfile_sweep_master;

   localparam int W = 32;
   localparam int N = 5;
   localparam int S = 32;

   logic           CLK = 1'b0;
   logic           RST_N = 1'b0;
   logic           START = 1'b0;
   logic           START_MODE = 1'b0;
   logic [N-1:0]   START_BASE = '0;
   logic [N:0]     START_COUNT = '0;
   logic [W-1:0]   START_SEED = '0;
   logic           START_INC = 1'b0;
   logic           BUSY, DONE, ERR;
   logic [W-1:0]   SUM;
   logic [N-1:0]   READ_REQ_WRITE;
   logic           READ_REQ_WRITE_VALID;
   logic [W-1:0]   READ_RESP_READ;
   logic           READ_RESP_READ_VALID = 1'b1;
   logic           WRITE_EN_WRITE;
   logic [N-1:0]   WRITE_INDEX_WRITE;
   logic [W-1:0]   WRITE_DATA_WRITE;
   logic           MISMATCH;
   logic [N-1:0]   MISMATCH_INDEX;

   regfile_sweep_master #(.width(W), .n(N), .size(S)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .START_MODE(START_MODE),
      .START_BASE(START_BASE), .START_COUNT(START_COUNT), .START_SEED(START_SEED),
      .START_INC(START_INC), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .SUM(SUM),
      .READ_REQ_WRITE(READ_REQ_WRITE), .READ_REQ_WRITE_VALID(READ_REQ_WRITE_VALID),
      .READ_RESP_READ(READ_RESP_READ), .READ_RESP_READ_VALID(READ_RESP_READ_VALID),
      .WRITE_EN_WRITE(WRITE_EN_WRITE), .WRITE_INDEX_WRITE(WRITE_INDEX_WRITE),
      .WRITE_DATA_WRITE(WRITE_DATA_WRITE), .MISMATCH(MISMATCH),
      .MISMATCH_INDEX(MISMATCH_INDEX)
   );

   always #5 CLK = ~CLK;

   // Target register file: registered write, combinational read.
   logic [W-1:0] mem [S];
   int           corrupt_idx = -1;

   always @(posedge CLK) begin
      if (WRITE_EN_WRITE) mem[WRITE_INDEX_WRITE] <= WRITE_DATA_WRITE;
   end

   assign READ_RESP_READ = (int'(READ_REQ_WRITE) == corrupt_idx) ? '0 : mem[READ_REQ_WRITE];

   typedef struct {
      bit           mode;
      logic [N-1:0] base;
      logic [N:0]   count;
      logic [W-1:0] seed;
      bit           inc;
      bit           exp_err;
      logic [W-1:0] exp_sum;   // meaningful for accepted check commands only
   } cmd_t;

   typedef struct {
      logic [N-1:0] idx;
      logic [W-1:0] data;
   } beat_t;

   beat_t        q[$];
   logic [W-1:0] shadow [S];
   logic [W-1:0] last_sum = '0;
   bit           exp_mm = 1'b0;
   logic [N-1:0] exp_mmi = '0;
   int           checks = 0;
   int           errors = 0;
   cmd_t         tbl [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_cmd(input cmd_t c, input int stall_at, input int stall_len, input bit poke);
      int    words;
      int    beats;
      int    stalled;
      int    err_cyc;
      int    done_cyc;
      int    cyc;
      logic [W-1:0] exp_sum;
      words    = c.exp_err ? 0 : int'(c.count);
      beats    = 0;
      stalled  = 0;
      err_cyc  = 0;
      done_cyc = 0;
      exp_sum  = last_sum;
      for (int i = 0; i < words; i++) begin
         beat_t b;
         b.idx  = c.base + N'(i);
         b.data = c.seed + (c.inc ? W'(i) : '0);
         q.push_back(b);
         if (!c.mode) shadow[b.idx] = b.data;
      end
      if (c.mode && words > 0) begin
         exp_sum = c.exp_sum;
`ifdef SWEEP_VERIFY_EN
         exp_mm  = 1'b0;
         exp_mmi = '0;
         for (int i = 0; i < words; i++) begin
            logic [N-1:0] a;
            logic [W-1:0] rd;
            a  = c.base + N'(i);
            rd = (int'(a) == corrupt_idx) ? '0 : shadow[a];
            if (!exp_mm && rd != c.seed + (c.inc ? W'(i) : '0)) begin
               exp_mm  = 1'b1;
               exp_mmi = a;
            end
         end
`endif
      end
      START_MODE  = c.mode;
      START_BASE  = c.base;
      START_COUNT = c.count;
      START_SEED  = c.seed;
      START_INC   = c.inc;
      START       = 1'b1;
      cyc = 0;
      while (cyc < words + stall_len + 6) begin
         tick();
         cyc++;
         START = 1'b0;
         START_BASE  = c.base;
         START_COUNT = c.count;
         if (ERR && err_cyc == 0) err_cyc = cyc;
         chk("busy", 64'(BUSY), 64'(words > 0 && cyc <= words + stall_len));
         if (WRITE_EN_WRITE) begin
            if (c.mode || q.size() == 0) chk("write_unexpected", 64'(WRITE_EN_WRITE), 64'(0));
            else begin
               beat_t b;
               b = q.pop_front();
               chk("write_index", 64'(WRITE_INDEX_WRITE), 64'(b.idx));
               chk("write_data", 64'(WRITE_DATA_WRITE), 64'(b.data));
            end
         end
         READ_RESP_READ_VALID = 1'b1;
         if (READ_REQ_WRITE_VALID) begin
            if (!c.mode || q.size() == 0) chk("read_unexpected", 64'(READ_REQ_WRITE_VALID), 64'(0));
            else begin
               chk("read_index", 64'(READ_REQ_WRITE), 64'(q[0].idx));
               if (beats == stall_at && stalled < stall_len) begin
                  READ_RESP_READ_VALID = 1'b0;
                  stalled++;
               end else begin
                  void'(q.pop_front());
                  beats++;
               end
            end
         end
         if (poke && cyc == 2) begin
            // Out-of-range command while busy must be ignored.
            START       = 1'b1;
            START_BASE  = 5'd31;
            START_COUNT = 6'd8;
         end
         if (DONE) begin
            done_cyc = cyc;
            break;
         end
         if (c.exp_err && cyc == 4) break;
      end
      START = 1'b0;
      READ_RESP_READ_VALID = 1'b1;
      if (c.exp_err) begin
         chk("err_cycle", 64'(err_cyc), 64'(1));
         chk("done_after_err", 64'(done_cyc), 64'(0));
      end else begin
         chk("done_cycle", 64'(done_cyc), 64'(words + stall_len + 1));
         chk("no_err", 64'(err_cyc), 64'(0));
      end
      chk("beats_left", 64'(q.size()), 64'(0));
      q.delete();
      chk("sum", 64'(SUM), 64'(exp_sum));
      chk("mismatch", 64'(MISMATCH), 64'(exp_mm));
      chk("mismatch_index", 64'(MISMATCH_INDEX), 64'(exp_mmi));
      last_sum = exp_sum;
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(BUSY), 64'(0));
      chk({tag, "_done"}, 64'(DONE), 64'(0));
      chk({tag, "_err"}, 64'(ERR), 64'(0));
      chk({tag, "_sum"}, 64'(SUM), 64'(0));
      chk({tag, "_rd_idx"}, 64'(READ_REQ_WRITE), 64'(0));
      chk({tag, "_rd_valid"}, 64'(READ_REQ_WRITE_VALID), 64'(0));
      chk({tag, "_wr_en"}, 64'(WRITE_EN_WRITE), 64'(0));
      chk({tag, "_wr_idx"}, 64'(WRITE_INDEX_WRITE), 64'(0));
      chk({tag, "_wr_data"}, 64'(WRITE_DATA_WRITE), 64'(0));
      chk({tag, "_mm"}, 64'(MISMATCH), 64'(0));
      chk({tag, "_mm_idx"}, 64'(MISMATCH_INDEX), 64'(0));
   endtask

   initial begin
      cmd_t c;
      //          mode base   count  seed           inc err sum
      tbl[0]  = '{1'b0, 5'd4,  6'd8,  32'h0000_0100, 1'b1, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 5'd4,  6'd8,  32'h0000_0100, 1'b1, 1'b0, 32'h0000_081C};
      tbl[2]  = '{1'b0, 5'd0,  6'd4,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 5'd0,  6'd4,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h7AB6_FBBC};
      tbl[4]  = '{1'b0, 5'd30, 6'd4,  32'h0000_0001, 1'b1, 1'b1, 32'h0};
      tbl[5]  = '{1'b0, 5'd5,  6'd0,  32'h0000_0001, 1'b1, 1'b0, 32'h0};
      tbl[6]  = '{1'b1, 5'd1,  6'd32, 32'h0000_0001, 1'b1, 1'b1, 32'h0};
      tbl[7]  = '{1'b0, 5'd31, 6'd1,  32'h0000_0055, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{1'b1, 5'd31, 6'd1,  32'h0000_0055, 1'b0, 1'b0, 32'h0000_0055};
      tbl[9]  = '{1'b1, 5'd4,  6'd8,  32'h0000_0100, 1'b1, 1'b0, 32'h0000_081C};
      tbl[10] = '{1'b0, 5'd0,  6'd32, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0};
      tbl[11] = '{1'b1, 5'd0,  6'd32, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0000_01B0};

      repeat (2) @(posedge CLK);
      #1;
      chk_all_zero("reset");
      RST_N = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) run_cmd(tbl[i], -1, 0, 1'b0);

      // Check with a three-cycle response stall after the third beat.
      run_cmd(tbl[1], 3, 3, 1'b1);

      // Word at index 7 reads back as zero.
      corrupt_idx = 7;
      c = tbl[1];
      c.exp_sum = 32'h0000_0719;
      run_cmd(c, -1, 0, 1'b0);
      corrupt_idx = -1;

      for (int i = 10; i < 12; i++) run_cmd(tbl[i], -1, 0, 1'b0);

      // Reset asserted during the third fill beat.
      START_MODE  = 1'b0;
      START_BASE  = 5'd0;
      START_COUNT = 6'd8;
      START_SEED  = 32'h0000_00A5;
      START_INC   = 1'b0;
      START       = 1'b1;
      tick();
      START = 1'b0;
      tick();
      tick();
      chk("third_beat_write", 64'(WRITE_EN_WRITE), 64'(1));
      #2;
      RST_N = 1'b0;
      #1;
      chk_all_zero("abort");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_no_done", 64'(DONE), 64'(0));
      end
      RST_N = 1'b1;
      tick();
      chk("after_abort_busy", 64'(BUSY), 64'(0));
      chk("after_abort_done", 64'(DONE), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
